snoop_bus: RTL

Shared snooping bus and arbiter for the MESI multiprocessor. It sits directly downstream of the per-processor cache controllers and upstream of main memory.
- Collects bus requests (read miss, write miss/invalidate) from the processors and grants the bus round-robin.
- Broadcasts each granted transaction to every other cache's snoop port.
- Handles dirty-owner write-back with memory abort, or a memory read, then returns the result to the requester.

---
 rtl/snoop_bus.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus.sv
// snoop_bus: round-robin arbiter and snooping broadcast bus for a MESI multiprocessor.
// Latency (req seen in IDLE to done): write 3, write or read with write-back 4, read from memory 5.
// Backpressure: requesters hold req (level) until their done pulse; ungranted requesters simply wait.
//
// Ports:
//   clock, reset_n          single clock, asynchronous active-low reset
//   req/req_op/req_addr     per-processor request level, op (1 = write/invalidate), address
//   snoop_hit/wb/data       snooper responses, sampled only at the edge that ends BCAST
//   mem_rdata               registered memory read data (1-cycle latency after mem_addr)
//   bus_valid/op/addr/owner broadcast strobe, op, address and one-hot current grant
//   mem_write/addr/wdata    memory write port and shared memory address
//   done/rdata/shared       one-hot completion pulse, fill data, line-shared indication
//   bus_err                 pulse when more than one snooper claims Modified ownership

module snoop_bus #(
    parameter int N_PROC = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_PROC-1:0]        req,
    input  logic [N_PROC-1:0]        req_op,
    input  logic [N_PROC*ADDR_W-1:0] req_addr,
    input  logic [N_PROC-1:0]        snoop_hit,
    input  logic [N_PROC-1:0]        snoop_wb,
    input  logic [N_PROC*DATA_W-1:0] snoop_data,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     bus_valid,
    output logic                     bus_op,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [N_PROC-1:0]        bus_owner,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [N_PROC-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     shared,
    output logic                     bus_err
);

    localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BCAST = 3'd1,
        S_WB    = 3'd2,
        S_MRD0  = 3'd3,
        S_MRD1  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State and transaction latches
    // ------------------------------------------------------------------
    state_t              state_q,  state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;   // index of the last processor granted
    logic [N_PROC-1:0]   grant_q,  grant_d;    // one-hot grant of the transaction in flight
    logic                op_q,     op_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [N_PROC-1:0]   hit_q,    hit_d;      // other caches holding a valid copy
    logic [N_PROC-1:0]   wb_q,     wb_d;       // other caches holding the line Modified
    logic [DATA_W-1:0]   wbdat_q,  wbdat_d;    // dirty data captured at the end of BCAST
    logic [DATA_W-1:0]   rdata_q,  rdata_d;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan rr_ptr+1, rr_ptr+2, ... wrapping modulo N_PROC.
    // cand stays below 2*N_PROC, so one conditional subtract replaces a modulo.
    // ------------------------------------------------------------------
    logic              arb_found;
    logic [PW-1:0]     arb_idx;
    logic [N_PROC-1:0] arb_gnt;
    int                cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        arb_gnt   = '0;
        cand      = 0;
        for (int k = 1; k <= N_PROC; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_PROC) begin
                cand = cand - N_PROC;
            end
            if (!arb_found && req[cand[PW-1:0]]) begin
                arb_found                = 1'b1;
                arb_idx                  = cand[PW-1:0];
                arb_gnt[cand[PW-1:0]]    = 1'b1;
            end
        end
    end

    // Op and address of the winning requester
    logic              sel_op;
    logic [ADDR_W-1:0] sel_addr;

    always_comb begin
        sel_op   = 1'b0;
        sel_addr = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (arb_gnt[i]) begin
                sel_op   = req_op[i];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Snoop response handling. The requester's own snooper sees its own
    // broadcast, so its bits are masked off before anything is recorded.
    // ------------------------------------------------------------------
    logic [N_PROC-1:0] hit_mask;
    logic [N_PROC-1:0] wb_mask;
    logic [DATA_W-1:0] wb_pick;

    assign hit_mask = snoop_hit & ~grant_q;
    assign wb_mask  = snoop_wb  & ~grant_q;

    // Descending scan so the lowest-index Modified owner wins if several claim it
    always_comb begin
        wb_pick = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (wb_mask[i]) begin
                wb_pick = snoop_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // More than one bit set in the recorded write-back vector
    logic wb_multi;
    assign wb_multi = ((wb_q & (wb_q - N_PROC'(1))) != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        addr_d   = addr_q;
        hit_d    = hit_q;
        wb_d     = wb_q;
        wbdat_d  = wbdat_q;
        rdata_d  = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d  = arb_gnt;
                    op_d     = sel_op;
                    addr_d   = sel_addr;
                    rr_ptr_d = arb_idx;
                    state_d  = S_BCAST;
                end
            end

            S_BCAST: begin
                hit_d   = hit_mask;
                wb_d    = wb_mask;
                wbdat_d = wb_pick;
                if (wb_mask != '0) begin
                    state_d = S_WB;
                end else if (!op_q) begin
                    state_d = S_MRD0;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_WB: begin
                // A read is served by the dirty owner; the memory read never starts
                if (!op_q) begin
                    rdata_d = wbdat_q;
                end
                state_d = S_DONE;
            end

            S_MRD0: begin
                state_d = S_MRD1;
            end

            S_MRD1: begin
                // Memory data for the address presented in MRD0 is valid now
                rdata_d = mem_rdata;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= PW'(N_PROC - 1);
            grant_q  <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            hit_q    <= '0;
            wb_q     <= '0;
            wbdat_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            hit_q    <= hit_d;
            wb_q     <= wb_d;
            wbdat_q  <= wbdat_d;
            rdata_q  <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus_valid = 1'b0;
        bus_op    = 1'b0;
        bus_addr  = '0;
        bus_owner = '0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = '0;
        shared    = 1'b0;
        bus_err   = 1'b0;
        rdata     = rdata_q;

        // Ownership, op and address stay visible for the whole transaction
        if (state_q != S_IDLE) begin
            bus_owner = grant_q;
            bus_op    = op_q;
            bus_addr  = addr_q;
        end

        case (state_q)
            S_BCAST: begin
                bus_valid = 1'b1;
            end
            S_WB: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wbdat_q;
                bus_err   = wb_multi;
            end
            S_MRD0, S_MRD1: begin
                mem_addr = addr_q;
            end
            S_DONE: begin
                done   = grant_q;
                shared = (hit_q != '0) || (wb_q != '0);
            end
            default: begin
            end
        endcase
    end

endmodule
